imem_arbiter: RTL and testbench

Shares the single-port instruction BRAM between the IF stage fetch port and the PS-side program loader, which writes and reads back program images.
- Grants at most one access per cycle.
- Tracks in-flight reads so each read's data returns only to the requester that issued it.
- Drives the IF-stage stall and discards stale fetch data on a PC redirect (pcsrc).
- Sits between if_stage, the loader bridge and the instruction memory.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_resp_pipe.sv | 41 ++++
 rtl/imem_arbiter.sv | 116 +++++++++++
 tb/tb_imem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter and its response pipeline.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W = 32;
  localparam int unsigned IMEM_DATA_W = 32;

  typedef enum logic {
    OwnerFetch,
    OwnerLoad
  } req_owner_t;

  typedef struct packed {
    logic       valid;
    req_owner_t owner;
    logic       killed;
  } mem_tag_t;

  typedef enum logic {
    PriLoad,
    PriFetch
  } arb_state_t;

  localparam mem_tag_t TagIdle = '{valid: 1'b0, owner: OwnerFetch, killed: 1'b0};

endpackage

// File: rtl/imem_resp_pipe.sv
// MEM_LAT-deep tag shift register that follows each BRAM read to its requester.
module imem_resp_pipe
  import imem_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid_i,
  input  req_owner_t push_owner_i,
  input  logic       kill_i,
  output mem_tag_t   out_tag_o
);

  mem_tag_t tag_q [MEM_LAT];
  mem_tag_t tag_d [MEM_LAT];

  // A tag entering this cycle belongs to the new PC, so only older stages see the kill.
  always_comb begin
    tag_d[0] = '{valid: push_valid_i, owner: push_owner_i, killed: 1'b0};
    for (int i = 1; i < int'(MEM_LAT); i++) begin
      tag_d[i] = tag_q[i-1];
      if (kill_i && (tag_q[i-1].owner == OwnerFetch)) begin
        tag_d[i].killed = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(MEM_LAT); i++) begin
      if (rst) begin
        tag_q[i] <= TagIdle;
      end else begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign out_tag_o = tag_q[MEM_LAT-1];

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction BRAM arbiter between the IF-stage fetch port and the program loader.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned DATA_W   = IMEM_DATA_W,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned LOAD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_stall,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned        StreakW   = $clog2(LOAD_MAX + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(LOAD_MAX);

  arb_state_t         state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic               pick_fetch, pick_load;
  mem_tag_t           out_tag;

  always_comb begin
    pick_fetch = 1'b0;
    pick_load  = 1'b0;
    case (state_q)
      PriFetch: begin
        pick_fetch = f_req;
        pick_load  = l_req & ~f_req;
      end
      default: begin
        pick_load  = l_req;
        pick_fetch = f_req & ~l_req;
      end
    endcase
    f_gnt = pick_fetch & ~rst;
    l_gnt = pick_load & ~rst;
  end

  // Fetch gets one guaranteed slot after LOAD_MAX loader wins in a row while it waited.
  always_comb begin
    state_d  = PriLoad;
    streak_d = streak_q;
    if (!f_req || f_gnt) begin
      streak_d = '0;
    end else if (l_gnt) begin
      streak_d = streak_q + 1'b1;
    end
    if (streak_d == StreakMax) begin
      state_d  = PriFetch;
      streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PriLoad;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    m_en    = f_gnt | l_gnt;
    m_we    = l_gnt & l_we;
    m_addr  = '0;
    m_wdata = '0;
    if (l_gnt) begin
      m_addr  = l_addr;
      m_wdata = l_wdata;
    end else if (f_gnt) begin
      m_addr = f_addr;
    end
  end

  assign f_stall = f_req & ~f_gnt;

  imem_resp_pipe #(
    .MEM_LAT(MEM_LAT)
  ) u_resp_pipe (
    .clk         (clk),
    .rst         (rst),
    .push_valid_i(m_en & ~m_we),
    .push_owner_i(f_gnt ? OwnerFetch : OwnerLoad),
    .kill_i      (f_flush),
    .out_tag_o   (out_tag)
  );

  // A fetch word landing in the redirect cycle is just as stale as the ones still in flight.
  assign f_rvalid = ~rst & out_tag.valid & (out_tag.owner == OwnerFetch) & ~out_tag.killed
                    & ~f_flush;
  assign l_rvalid = ~rst & out_tag.valid & (out_tag.owner == OwnerLoad);
  assign f_rdata  = m_rdata;
  assign l_rdata  = m_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 1..3) share one stimulus, each with its own BRAM model.
module tb_imem_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req, f_flush, l_req, l_we;
  logic [31:0] f_addr, l_addr, l_wdata;

  logic [3:1]        f_gnt_v, f_stall_v, f_rvalid_v, l_gnt_v, l_rvalid_v, m_en_v, m_we_v;
  logic [3:1][31:0]  f_rdata_v, l_rdata_v, m_addr_v, m_wdata_v, m_rdata_v;

  int errors;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 1; g <= 3; g++) begin : g_lat
    logic [31:0] mem  [256];
    logic [31:0] rd_q [g];
    logic        rv_q [g];

    imem_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .MEM_LAT (g),
      .LOAD_MAX(4)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .f_req   (f_req),
      .f_addr  (f_addr),
      .f_flush (f_flush),
      .f_gnt   (f_gnt_v[g]),
      .f_stall (f_stall_v[g]),
      .f_rvalid(f_rvalid_v[g]),
      .f_rdata (f_rdata_v[g]),
      .l_req   (l_req),
      .l_we    (l_we),
      .l_addr  (l_addr),
      .l_wdata (l_wdata),
      .l_gnt   (l_gnt_v[g]),
      .l_rvalid(l_rvalid_v[g]),
      .l_rdata (l_rdata_v[g]),
      .m_en    (m_en_v[g]),
      .m_we    (m_we_v[g]),
      .m_addr  (m_addr_v[g]),
      .m_wdata (m_wdata_v[g]),
      .m_rdata (m_rdata_v[g])
    );

    // Word at byte address a starts as 0xC0DE0000 + a.
    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 4);
    end

    always @(posedge clk) begin
      if (m_en_v[g] && m_we_v[g]) mem[m_addr_v[g][9:2]] <= m_wdata_v[g];
      rd_q[0] <= mem[m_addr_v[g][9:2]];
      rv_q[0] <= m_en_v[g] & ~m_we_v[g];
      for (int i = 1; i < g; i++) begin
        rd_q[i] <= rd_q[i-1];
        rv_q[i] <= rv_q[i-1];
      end
    end

    assign m_rdata_v[g] = rv_q[g-1] ? rd_q[g-1] : 32'hxxxx_xxxx;
  end

  task automatic drive(input logic r, input logic fr, input logic [31:0] fa, input logic ff,
                       input logic lr, input logic lwe, input logic [31:0] la,
                       input logic [31:0] lwd);
    @(negedge clk);
    rst     = r;
    f_req   = fr;
    f_addr  = fa;
    f_flush = ff;
    l_req   = lr;
    l_we    = lwe;
    l_addr  = la;
    l_wdata = lwd;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 32'h8, 32'hFF);
      for (int g = 1; g <= 3; g++) begin
        checks++;
        if ({f_gnt_v[g], l_gnt_v[g], m_en_v[g], m_we_v[g], f_rvalid_v[g], l_rvalid_v[g]}
            !== 6'b0) begin
          errors++;
          $display("FAIL reset_ctrl lat%0d: got gnt/en/we/rv=%b want 000000", g,
                   {f_gnt_v[g], l_gnt_v[g], m_en_v[g], m_we_v[g], f_rvalid_v[g], l_rvalid_v[g]});
        end
        checks++;
        if ({m_addr_v[g], m_wdata_v[g]} !== 64'h0) begin
          errors++;
          $display("FAIL reset_bus lat%0d: got addr=%h wdata=%h want 0", g, m_addr_v[g],
                   m_wdata_v[g]);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_fetch_only();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, k < 3, 32'(k * 4), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (f_gnt_v[1] !== (k < 3)) begin
        errors++;
        $display("FAIL fetch_gnt c%0d: got %b want %b", k, f_gnt_v[1], k < 3);
      end
      checks++;
      if ({f_stall_v[1], l_gnt_v[1]} !== 2'b00) begin
        errors++;
        $display("FAIL fetch_stall_lgnt c%0d: got %b want 00", k, {f_stall_v[1], l_gnt_v[1]});
      end
      checks++;
      if (f_rvalid_v[1] !== (k > 0)) begin
        errors++;
        $display("FAIL fetch_rvalid c%0d: got %b want %b", k, f_rvalid_v[1], k > 0);
      end
      if (k > 0) begin
        checks++;
        if (f_rdata_v[1] !== 32'hC0DE_0000 + 32'((k - 1) * 4)) begin
          errors++;
          $display("FAIL fetch_rdata c%0d: got %h want %h", k, f_rdata_v[1],
                   32'hC0DE_0000 + 32'((k - 1) * 4));
        end
      end
    end
    idle(4);
  endtask

  task automatic test_load_burst();
    int          w;
    logic        exp_l;
    logic [31:0] exp_addr;
    w = 0;
    for (int k = 0; k < 9; k++) begin
      exp_l    = (k != 4);
      exp_addr = exp_l ? 32'h100 + 32'(w * 4) : 32'h20;
      drive(1'b0, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 32'h100 + 32'(w * 4), 32'h5A00_0000 | 32'(w));
      checks++;
      if ({l_gnt_v[1], f_gnt_v[1], f_stall_v[1], m_we_v[1]} !== {exp_l, ~exp_l, exp_l, exp_l})
      begin
        errors++;
        $display("FAIL burst_gnt c%0d: got lgnt/fgnt/stall/we=%b want %b", k,
                 {l_gnt_v[1], f_gnt_v[1], f_stall_v[1], m_we_v[1]},
                 {exp_l, ~exp_l, exp_l, exp_l});
      end
      checks++;
      if (m_addr_v[1] !== exp_addr) begin
        errors++;
        $display("FAIL burst_addr c%0d: got %h want %h", k, m_addr_v[1], exp_addr);
      end
      if (k == 5) begin
        checks++;
        if ({f_rvalid_v[1], f_rdata_v[1]} !== {1'b1, 32'hC0DE_0020}) begin
          errors++;
          $display("FAIL burst_fetch_data: got v=%b d=%h want v=1 d=c0de0020", f_rvalid_v[1],
                   f_rdata_v[1]);
        end
      end
      if (exp_l) w++;
    end
    idle(4);
  endtask

  task automatic test_readback();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, k == 1, 32'h8, 1'b0, k == 0, 1'b0, 32'h100, 32'h0);
      checks++;
      if ({l_gnt_v[2], f_gnt_v[2]} !== {k == 0, k == 1}) begin
        errors++;
        $display("FAIL rb_gnt c%0d: got l/f=%b want %b", k, {l_gnt_v[2], f_gnt_v[2]},
                 {k == 0, k == 1});
      end
      checks++;
      if ({l_rvalid_v[2], f_rvalid_v[2]} !== {k == 2, k == 3}) begin
        errors++;
        $display("FAIL rb_rvalid c%0d: got l/f=%b want %b", k, {l_rvalid_v[2], f_rvalid_v[2]},
                 {k == 2, k == 3});
      end
      if (k == 2) begin
        checks++;
        if (l_rdata_v[2] !== 32'h5A00_0000) begin
          errors++;
          $display("FAIL rb_ldata: got %h want 5a000000", l_rdata_v[2]);
        end
      end
      if (k == 3) begin
        checks++;
        if (f_rdata_v[2] !== 32'hC0DE_0008) begin
          errors++;
          $display("FAIL rb_fdata: got %h want c0de0008", f_rdata_v[2]);
        end
      end
    end
    idle(4);
  endtask

  task automatic test_flush();
    logic [31:0] fa;
    for (int k = 0; k < 7; k++) begin
      fa = (k == 2) ? 32'h40 : 32'(k * 4);
      drive(1'b0, k < 3, fa, k == 2, 1'b0, 1'b0, 32'h0, 32'h0);
      if (k == 2) begin
        checks++;
        if (f_gnt_v[3] !== 1'b1) begin
          errors++;
          $display("FAIL flush_gnt: got %b want 1", f_gnt_v[3]);
        end
      end
      checks++;
      if (f_rvalid_v[3] !== (k == 5)) begin
        errors++;
        $display("FAIL flush_rvalid c%0d: got %b want %b", k, f_rvalid_v[3], k == 5);
      end
      if (k == 5) begin
        checks++;
        if (f_rdata_v[3] !== 32'hC0DE_0040) begin
          errors++;
          $display("FAIL flush_rdata: got %h want c0de0040", f_rdata_v[3]);
        end
      end
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h104, 32'h0);
    checks++;
    if ({l_gnt_v[1], f_stall_v[1]} !== 2'b11) begin
      errors++;
      $display("FAIL rmid_lgnt: got lgnt/stall=%b want 11", {l_gnt_v[1], f_stall_v[1]});
    end
    drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h104, 32'h0);
    checks++;
    if ({l_rvalid_v, f_gnt_v[1], l_gnt_v[1]} !== 5'b0) begin
      errors++;
      $display("FAIL rmid_in_rst: got lrv3..1=%b f/lgnt=%b want 0", l_rvalid_v,
               {f_gnt_v[1], l_gnt_v[1]});
    end
    drive(1'b0, 1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if ({f_gnt_v[1], f_stall_v[1], l_rvalid_v} !== 5'b10000) begin
      errors++;
      $display("FAIL rmid_first_fetch: got fgnt/stall/lrv=%b want 10000",
               {f_gnt_v[1], f_stall_v[1], l_rvalid_v});
    end
    drive(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h104, 32'h0);
    checks++;
    if ({l_gnt_v[1], f_gnt_v[1], l_rvalid_v} !== 5'b10000) begin
      errors++;
      $display("FAIL rmid_priority: got l/fgnt/lrv=%b want 10000",
               {l_gnt_v[1], f_gnt_v[1], l_rvalid_v});
    end
    checks++;
    if ({f_rvalid_v[1], f_rdata_v[1]} !== {1'b1, 32'hC0DE_000C}) begin
      errors++;
      $display("FAIL rmid_fdata: got v=%b d=%h want v=1 d=c0de000c", f_rvalid_v[1],
               f_rdata_v[1]);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if ({l_rvalid_v[1], l_rdata_v[1]} !== {1'b1, 32'h5A00_0001}) begin
      errors++;
      $display("FAIL rmid_ldata: got v=%b d=%h want v=1 d=5a000001", l_rvalid_v[1],
               l_rdata_v[1]);
    end
    idle(4);
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if ({m_en_v, f_gnt_v, l_gnt_v, f_rvalid_v, l_rvalid_v} !== 15'b0) begin
        errors++;
        $display("FAIL idle c%0d: got en/fg/lg/frv/lrv=%b want 0", k,
                 {m_en_v, f_gnt_v, l_gnt_v, f_rvalid_v, l_rvalid_v});
      end
    end
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h1234);
    checks++;
    if ({l_gnt_v[1], f_gnt_v[1], f_stall_v[1], m_we_v[1]} !== 4'b1011) begin
      errors++;
      $display("FAIL simul_gnt: got l/f/stall/we=%b want 1011",
               {l_gnt_v[1], f_gnt_v[1], f_stall_v[1], m_we_v[1]});
    end
    checks++;
    if ({m_addr_v[1], m_wdata_v[1]} !== {32'h200, 32'h1234}) begin
      errors++;
      $display("FAIL simul_bus: got addr=%h wdata=%h want 200/1234", m_addr_v[1],
               m_wdata_v[1]);
    end
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if ({f_gnt_v[1], l_gnt_v[1]} !== 2'b10) begin
      errors++;
      $display("FAIL simul_after: got f/lgnt=%b want 10", {f_gnt_v[1], l_gnt_v[1]});
    end
    idle(4);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    f_req   = 1'b0;
    f_addr  = 32'h0;
    f_flush = 1'b0;
    l_req   = 1'b0;
    l_we    = 1'b0;
    l_addr  = 32'h0;
    l_wdata = 32'h0;
    test_reset();
    test_fetch_only();
    test_load_burst();
    test_readback();
    test_flush();
    test_reset_mid();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
